// File: rtl/recovery_rate_tracker_if.sv
// Event/drift inputs and rate/lock outputs of recovery_rate_tracker; master drives the events, slave is the tracker.
// No latency or backpressure of its own: plain wires.
interface recovery_rate_tracker_if #(
    parameter int W = 16
);
    logic         enable;
    logic         clear_lock;
    logic [W-1:0] timeout_limit;
    logic         primary_event;
    logic         positive_drift_violation;
    logic         negative_drift_violation;
    logic [W-1:0] pending_rate;
    logic [W-1:0] validated_rate;
    logic         rate_locked_in;
    logic         lock_lost;
    logic         timeout;

    modport master (
        output enable, clear_lock, timeout_limit, primary_event,
               positive_drift_violation, negative_drift_violation,
        input  pending_rate, validated_rate, rate_locked_in, lock_lost, timeout
    );

    modport slave (
        input  enable, clear_lock, timeout_limit, primary_event,
               positive_drift_violation, negative_drift_violation,
        output pending_rate, validated_rate, rate_locked_in, lock_lost, timeout
    );
endinterface

// File: rtl/recovery_rate_tracker.sv
// Event-interval tracker: acquire/train/lock/loss FSM; RECOVERY_RATE_AVERAGING_EN averages the LOCKED update.
// Outputs registered, 1 cycle after the triggering event; no backpressure, every event is consumed.
module recovery_rate_tracker #(
    parameter int RATE_COUNTER_WIDTH = 16, // system-wide rate width (clks_alot_p::RATE_COUNTER_WIDTH)
    parameter int LOCKIN_COUNT       = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    recovery_rate_tracker_if.slave bus
);
    localparam int W  = RATE_COUNTER_WIDTH;
    localparam int CW = $clog2(LOCKIN_COUNT + 1);
    localparam logic [W-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKIN_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRAINING, LOCKED} state_t;

    state_t        state, state_n;
    logic          armed, armed_n;
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    logic [W-1:0]  cnt, cnt_n;
    logic [W-1:0]  validated, validated_n;
    logic          lock_lost, lock_lost_n;
    logic          timeout, timeout_n;
    logic          drift_ok;
    logic          timed_out;
    logic [W-1:0]  locked_update;

`ifdef RECOVERY_RATE_AVERAGING_EN
    logic [W:0] avg_sum;
    assign avg_sum       = {1'b0, validated} + {1'b0, cnt};
    assign locked_update = avg_sum[W:1];
`else
    assign locked_update = cnt;
`endif

    assign drift_ok  = ~(bus.positive_drift_violation | bus.negative_drift_violation);
    // A zero limit disables loss-of-signal detection.
    assign timed_out = (bus.timeout_limit != '0) && (cnt >= bus.timeout_limit);

    always_comb begin
        state_n     = state;
        armed_n     = armed;
        lock_cnt_n  = lock_cnt;
        validated_n = validated;
        lock_lost_n = 1'b0;
        timeout_n   = 1'b0;
        if (bus.primary_event)
            cnt_n = W'(1);
        else if (cnt == CNT_MAX)
            cnt_n = cnt;
        else
            cnt_n = cnt + W'(1);

        if (!bus.enable) begin
            state_n     = IDLE;
            armed_n     = 1'b0;
            lock_cnt_n  = '0;
            cnt_n       = '0;
            validated_n = '0;
        end else if (bus.clear_lock) begin
            state_n     = ACQUIRE;
            armed_n     = 1'b0;
            lock_cnt_n  = '0;
            lock_lost_n = (state == LOCKED);
        end else begin
            case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    // The first event only gives a start point; the second closes a real interval.
                    if (bus.primary_event) begin
                        if (!armed) begin
                            armed_n = 1'b1;
                        end else begin
                            armed_n     = 1'b0;
                            validated_n = cnt;
                            lock_cnt_n  = '0;
                            state_n     = TRAINING;
                        end
                    end
                end
                TRAINING: begin
                    if (bus.primary_event) begin
                        validated_n = cnt;
                        if (drift_ok) begin
                            lock_cnt_n = lock_cnt + CW'(1);
                            if (lock_cnt == LOCK_LAST)
                                state_n = LOCKED;
                        end else begin
                            lock_cnt_n = '0;
                        end
                    end else if (timed_out) begin
                        timeout_n  = 1'b1;
                        lock_cnt_n = '0;
                        state_n    = ACQUIRE;
                    end
                end
                LOCKED: begin
                    if (bus.primary_event) begin
                        if (drift_ok)
                            validated_n = locked_update;
                    end else if (timed_out) begin
                        timeout_n   = 1'b1;
                        lock_lost_n = 1'b1;
                        lock_cnt_n  = '0;
                        state_n     = ACQUIRE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            lock_cnt  <= '0;
            cnt       <= '0;
            validated <= '0;
            lock_lost <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            armed     <= armed_n;
            lock_cnt  <= lock_cnt_n;
            cnt       <= cnt_n;
            validated <= validated_n;
            lock_lost <= lock_lost_n;
            timeout   <= timeout_n;
        end
    end

    assign bus.pending_rate   = cnt;
    assign bus.validated_rate = validated;
    assign bus.rate_locked_in = (state == LOCKED);
    assign bus.lock_lost      = lock_lost;
    assign bus.timeout        = timeout;
endmodule
